// File: rtl/mem_stage_pkg.sv
// Shared processor package: MEM-stage opcode constants, stack pointer reset value
// and the opcode classifier used by mem_stage.
package mem_stage_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;
    localparam logic [3:0] OP_PUSH  = 4'hE;
    localparam logic [3:0] OP_POP   = 4'hF;

    localparam logic [7:0] SP_INIT  = 8'hFF;

    typedef enum logic [2:0] {
        K_NOP   = 3'd0,
        K_ALU   = 3'd1,
        K_LOAD  = 3'd2,
        K_STORE = 3'd3,
        K_PUSH  = 3'd4,
        K_POP   = 3'd5
    } op_kind_e;

    // Stack opcodes collapse to NOP when the stack is not built.
    function automatic op_kind_e decode_op(input logic [3:0] opcode, input logic stack_en);
        op_kind_e kind;
        case (opcode)
            OP_NOP:   kind = K_NOP;
            OP_LOAD:  kind = K_LOAD;
            OP_STORE: kind = K_STORE;
            OP_PUSH:  kind = stack_en ? K_PUSH : K_NOP;
            OP_POP:   kind = stack_en ? K_POP  : K_NOP;
            default:  kind = K_ALU;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Data RAM for the MEM stage: DEPTH x 8, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module data_ram #(
    parameter int DEPTH = 256
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: loads, stores, optional stack ops, registered MEM/WB bundle.
// Stack (PUSH/POP and the SP register) is built only when MEM_STAGE_STACK_EN is defined.
module mem_stage #(
    parameter int         DEPTH   = 256,
    parameter logic [7:0] SP_INIT = mem_stage_pkg::SP_INIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       stall,
    input  logic [7:0] EXMEM_result,
    input  logic [7:0] EXMEM_operand_b,
    input  logic [7:0] EXMEM_address,
    input  logic [3:0] EXMEM_opcode,
    input  logic [1:0] EXMEM_ra,
    input  logic [1:0] EXMEM_rb,
    input  logic       EXMEM_valid,
    input  logic [3:0] EXMEM_flags,
    output logic [7:0] MEMWB_data,
    output logic [1:0] MEMWB_ra,
    output logic       MEMWB_wen,
    output logic       MEMWB_valid,
    output logic [3:0] MEMWB_flags,
    output logic [7:0] sp_out
);

    import mem_stage_pkg::*;

`ifdef MEM_STAGE_STACK_EN
    localparam logic STACK_EN = 1'b1;
`else
    localparam logic STACK_EN = 1'b0;
`endif

    op_kind_e   kind_s;
    logic       live_s;
    logic [7:0] sp_s;
    logic       ram_we_s;
    logic [7:0] ram_waddr_s;
    logic [7:0] ram_wdata_s;
    logic [7:0] ram_raddr_s;
    logic [7:0] ram_rdata_s;
    logic [7:0] data_nxt_s;
    logic       wen_nxt_s;
    logic [1:0] rb_unused_s;

    assign kind_s      = decode_op(EXMEM_opcode, STACK_EN);
    assign live_s      = EXMEM_valid & ~stall & ~flush;
    assign rb_unused_s = EXMEM_rb;

    // RAM port steering; the reset term stops a write landing on the edge reset is low
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = EXMEM_address;
        ram_wdata_s = EXMEM_operand_b;
        ram_raddr_s = EXMEM_address;
        case (kind_s)
            K_STORE: ram_we_s = live_s & reset;
            K_PUSH: begin
                ram_we_s    = live_s & reset;
                ram_waddr_s = sp_s;
            end
            K_POP:   ram_raddr_s = sp_s + 8'd1;
            default: ram_we_s = 1'b0;
        endcase
    end

    data_ram #(
        .DEPTH (DEPTH)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Write-back data selection
    always_comb begin
        data_nxt_s = 8'h00;
        wen_nxt_s  = 1'b0;
        case (kind_s)
            K_LOAD, K_POP: begin
                data_nxt_s = ram_rdata_s;
                wen_nxt_s  = live_s;
            end
            K_ALU: begin
                data_nxt_s = EXMEM_result;
                wen_nxt_s  = live_s;
            end
            default: begin
                data_nxt_s = 8'h00;
                wen_nxt_s  = 1'b0;
            end
        endcase
    end

    // MEM/WB bundle: flush bubbles even while stalled, stall freezes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MEMWB_data  <= 8'h00;
            MEMWB_ra    <= 2'd0;
            MEMWB_wen   <= 1'b0;
            MEMWB_valid <= 1'b0;
            MEMWB_flags <= 4'h0;
        end else if (flush) begin
            MEMWB_data  <= 8'h00;
            MEMWB_ra    <= 2'd0;
            MEMWB_wen   <= 1'b0;
            MEMWB_valid <= 1'b0;
            MEMWB_flags <= 4'h0;
        end else if (!stall) begin
            MEMWB_data  <= data_nxt_s;
            MEMWB_ra    <= EXMEM_ra;
            MEMWB_wen   <= wen_nxt_s;
            MEMWB_valid <= EXMEM_valid;
            MEMWB_flags <= EXMEM_flags;
        end
    end

`ifdef MEM_STAGE_STACK_EN
    logic [7:0] sp_r;

    // Stack pointer: descending stack, SP names the next free slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_r <= SP_INIT;
        end else if (live_s && kind_s == K_PUSH) begin
            sp_r <= sp_r - 8'd1;
        end else if (live_s && kind_s == K_POP) begin
            sp_r <= sp_r + 8'd1;
        end
    end

    assign sp_s = sp_r;
`else
    assign sp_s = SP_INIT;
`endif

    assign sp_out = sp_s;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: behavioural RAM/stack model, per-cycle compare,
// directed scenarios and randomized traffic. Honours MEM_STAGE_STACK_EN.
module tb_mem_stage;

    import mem_stage_pkg::*;

`ifdef MEM_STAGE_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] EXMEM_result = 8'h00;
    logic [7:0] EXMEM_operand_b = 8'h00;
    logic [7:0] EXMEM_address = 8'h00;
    logic [3:0] EXMEM_opcode = 4'h0;
    logic [1:0] EXMEM_ra = 2'd0;
    logic [1:0] EXMEM_rb = 2'd0;
    logic       EXMEM_valid = 1'b0;
    logic [3:0] EXMEM_flags = 4'h0;
    logic [7:0] MEMWB_data;
    logic [1:0] MEMWB_ra;
    logic       MEMWB_wen;
    logic       MEMWB_valid;
    logic [3:0] MEMWB_flags;
    logic [7:0] sp_out;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .stall           (stall),
        .EXMEM_result    (EXMEM_result),
        .EXMEM_operand_b (EXMEM_operand_b),
        .EXMEM_address   (EXMEM_address),
        .EXMEM_opcode    (EXMEM_opcode),
        .EXMEM_ra        (EXMEM_ra),
        .EXMEM_rb        (EXMEM_rb),
        .EXMEM_valid     (EXMEM_valid),
        .EXMEM_flags     (EXMEM_flags),
        .MEMWB_data      (MEMWB_data),
        .MEMWB_ra        (MEMWB_ra),
        .MEMWB_wen       (MEMWB_wen),
        .MEMWB_valid     (MEMWB_valid),
        .MEMWB_flags     (MEMWB_flags),
        .sp_out          (sp_out)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference state: memory image, stack pointer, expected write-back bundle
    logic [7:0] m_ram [256];
    logic [7:0] m_sp = 8'hFF;
    logic [7:0] e_data = 8'h00;
    logic [1:0] e_ra = 2'd0;
    logic       e_wen = 1'b0;
    logic       e_valid = 1'b0;
    logic [3:0] e_flags = 4'h0;
    logic       e_dchk = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, just after each rising edge
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("wen", MEMWB_wen, e_wen);
            chk("valid", MEMWB_valid, e_valid);
            chk("ra", MEMWB_ra, e_ra);
            chk("flags", MEMWB_flags, e_flags);
            chk("sp_out", sp_out, m_sp);
            if (e_dchk) chk("data", MEMWB_data, e_data);
        end
    end

    task automatic model_clear();
        e_data = 8'h00; e_ra = 2'd0; e_wen = 1'b0; e_valid = 1'b0; e_flags = 4'h0; e_dchk = 1'b1;
    endtask

    // Architectural effect of the op presented for the coming edge
    task automatic model_apply(input logic [3:0] op, input logic [7:0] addr, input logic [7:0] b,
                               input logic [7:0] res, input logic [1:0] ra, input logic [3:0] fl_bits,
                               input logic v, input logic st, input logic fl);
        logic [7:0] above;
        above = m_sp + 8'd1;
        if (fl) begin
            model_clear();
        end else if (!st) begin
            e_valid = v; e_ra = ra; e_flags = fl_bits; e_wen = 1'b0; e_data = 8'h00;
            if (op == OP_LOAD) begin
                e_data = m_ram[addr]; e_wen = v;
            end else if (op == OP_STORE) begin
                if (v) m_ram[addr] = b;
            end else if (op == OP_PUSH) begin
                if (STK && v) begin m_ram[m_sp] = b; m_sp = m_sp - 8'd1; end
            end else if (op == OP_POP) begin
                if (STK) begin
                    e_data = m_ram[above]; e_wen = v;
                    if (v) m_sp = above;
                end
            end else if (op != OP_NOP) begin
                e_data = res; e_wen = v;
            end
            e_dchk = e_wen;
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] addr, input logic [7:0] b,
                         input logic [7:0] res, input logic [1:0] ra, input logic [3:0] fl_bits,
                         input logic v, input logic st, input logic fl);
        EXMEM_opcode = op; EXMEM_address = addr; EXMEM_operand_b = b; EXMEM_result = res;
        EXMEM_ra = ra; EXMEM_rb = ~ra; EXMEM_flags = fl_bits; EXMEM_valid = v;
        stall = st; flush = fl;
    endtask

    task automatic step(input logic [3:0] op, input logic [7:0] addr, input logic [7:0] b,
                        input logic [7:0] res, input logic [1:0] ra, input logic [3:0] fl_bits,
                        input logic v, input logic st, input logic fl);
        @(negedge clk);
        drive(op, addr, b, res, ra, fl_bits, v, st, fl);
        model_apply(op, addr, b, res, ra, fl_bits, v, st, fl);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Reset asserted mid-cycle while a PUSH is presented, then released with a bubble
    task automatic reset_during_push(input logic [7:0] b);
        @(negedge clk);
        drive(OP_PUSH, 8'h00, b, 8'h00, 2'd3, 4'hF, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        model_clear();
        m_sp = 8'hFF;
        #1;
        chk("rst_imm_valid", MEMWB_valid, 0);
        chk("rst_imm_data", MEMWB_data, 0);
        chk("rst_imm_ra", MEMWB_ra, 0);
        chk("rst_imm_sp", sp_out, 8'hFF);
        @(negedge clk);
        reset = 1'b1;
        drive(OP_NOP, 8'h00, 8'h00, 8'h00, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        model_apply(OP_NOP, 8'h00, 8'h00, 8'h00, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pre_sp;
        logic [3:0] op;
        logic [7:0] r8;
        for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
        model_clear();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", MEMWB_valid, 0);
        chk("rst_wen", MEMWB_wen, 0);
        chk("rst_sp", sp_out, 8'hFF);
        reset = 1'b1;

        // Known RAM image
        for (int i = 0; i < 256; i++) begin
            r8 = 8'($urandom);
            step(OP_STORE, 8'(i), r8, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        end

        // Store then load back
        step(OP_STORE, 8'h10, 8'hA5, 8'h00, 2'd0, 4'h1, 1'b1, 1'b0, 1'b0);
        step(OP_LOAD, 8'h10, 8'h00, 8'h00, 2'd2, 4'h2, 1'b1, 1'b0, 1'b0);
        settle();
        chk("ld_data", MEMWB_data, 8'hA5);
        chk("ld_wen", MEMWB_wen, 1);
        chk("ld_ra", MEMWB_ra, 2);

        // ALU passthrough
        step(4'h3, 8'h00, 8'h00, 8'h5E, 2'd1, 4'h9, 1'b1, 1'b0, 1'b0);
        settle();
        chk("alu_data", MEMWB_data, 8'h5E);

        // Stall holds outputs and blocks the stalled write
        step(OP_STORE, 8'h30, 8'h01, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(OP_LOAD, 8'h10, 8'h00, 8'h00, 2'd2, 4'h4, 1'b1, 1'b0, 1'b0);
        step(OP_STORE, 8'h30, 8'h99, 8'h00, 2'd1, 4'h7, 1'b1, 1'b1, 1'b0);
        step(OP_STORE, 8'h30, 8'h99, 8'h00, 2'd1, 4'h7, 1'b1, 1'b1, 1'b0);
        settle();
        chk("stall_hold_data", MEMWB_data, 8'hA5);
        chk("stall_hold_wen", MEMWB_wen, 1);
        step(OP_NOP, 8'h00, 8'h00, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(OP_LOAD, 8'h30, 8'h00, 8'h00, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("stall_nowrite", MEMWB_data, 8'h01);
        step(OP_STORE, 8'h20, 8'h11, 8'h00, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0);
        step(OP_STORE, 8'h20, 8'h11, 8'h00, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0);
        step(OP_STORE, 8'h20, 8'h11, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(OP_LOAD, 8'h20, 8'h00, 8'h00, 2'd1, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("stall_release_write", MEMWB_data, 8'h11);

        // Flush beats stall: bubble, no write
        step(OP_STORE, 8'h40, 8'h02, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(OP_STORE, 8'h40, 8'hEE, 8'h00, 2'd2, 4'hA, 1'b1, 1'b1, 1'b1);
        settle();
        chk("flush_valid", MEMWB_valid, 0);
        chk("flush_data", MEMWB_data, 0);
        step(OP_LOAD, 8'h40, 8'h00, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("flush_nowrite", MEMWB_data, 8'h02);

`ifdef MEM_STAGE_STACK_EN
        step(OP_PUSH, 8'h00, 8'h3C, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("push_sp", sp_out, 8'hFE);
        step(OP_POP, 8'h00, 8'h00, 8'h00, 2'd1, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("pop_data", MEMWB_data, 8'h3C);
        chk("pop_sp", sp_out, 8'hFF);
        for (int i = 0; i < 255; i++) step(OP_PUSH, 8'h00, 8'(i), 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("fill_sp", sp_out, 8'h00);
        step(OP_PUSH, 8'h00, 8'h77, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("wrap_push_sp", sp_out, 8'hFF);
        step(OP_LOAD, 8'h00, 8'h00, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("wrap_push_ram", MEMWB_data, 8'h77);
        step(OP_POP, 8'h00, 8'h00, 8'h00, 2'd2, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("wrap_pop_data", MEMWB_data, 8'h77);
        chk("wrap_pop_sp", sp_out, 8'h00);
`else
        step(OP_PUSH, 8'h00, 8'h3C, 8'h00, 2'd1, 4'h5, 1'b1, 1'b0, 1'b0);
        settle();
        chk("nostk_push_wen", MEMWB_wen, 0);
        chk("nostk_push_valid", MEMWB_valid, 1);
        chk("nostk_sp", sp_out, 8'hFF);
`endif

        // Reset during a PUSH must not disturb the slot at the old SP
        pre_sp = m_sp;
        reset_during_push(8'h55);
        step(OP_LOAD, pre_sp, 8'h00, 8'h00, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("rst_push_nowrite", MEMWB_data, m_ram[pre_sp]);
        chk("rst_push_sp", sp_out, 8'hFF);

        // Randomized traffic on a small address window to force collisions
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP_NOP;
                1: op = OP_LOAD;
                2: op = OP_STORE;
                3: op = OP_PUSH;
                4: op = OP_POP;
                default: op = 4'($urandom_range(1, 11));
            endcase
            step(op, 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 2'($urandom),
                 4'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0));
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data RAM entries, addressed by 8 bits.
REQ-002 SHALL have parameter SP_INIT, default 8'hFF, meaning stack pointer reset value.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous bubble insert into the MEM/WB outputs.
REQ-006 SHALL have port stall  input  1  hold all state this cycle.
REQ-007 SHALL have ports EXMEM_result/EXMEM_operand_b/EXMEM_address  input  8 each  ALU result, store data, memory address.
REQ-008 SHALL have ports EXMEM_opcode  input  4, EXMEM_ra/EXMEM_rb  input  2, EXMEM_valid  input  1, EXMEM_flags  input  4.
REQ-009 SHALL have outputs MEMWB_data  8, MEMWB_ra  2, MEMWB_wen  1, MEMWB_valid  1, MEMWB_flags  4: registered write-back bundle.
REQ-010 SHALL have output sp_out  8  current stack pointer.

Function
REQ-011 SHALL decode EXMEM_opcode as NOP=4'h0, LOAD=4'hC, STORE=4'hD, PUSH=4'hE, POP=4'hF; all other codes are ALU ops.
REQ-012 SHALL treat an op as live only when EXMEM_valid=1, stall=0 and flush=0.
REQ-013 Live STORE SHALL write EXMEM_operand_b to RAM[EXMEM_address] at the clock edge.
REQ-014 Live LOAD SHALL return RAM[EXMEM_address] (combinational read) in MEMWB_data one cycle later.
REQ-015 Live PUSH SHALL write EXMEM_operand_b to RAM[SP], then SP <= SP-1 (mod 256).
REQ-016 Live POP SHALL return RAM[SP+1] (mod 256) in MEMWB_data, then SP <= SP+1.
REQ-017 ALU ops SHALL pass EXMEM_result to MEMWB_data unchanged.
REQ-018 MEMWB_wen SHALL be 1 for a live LOAD, POP or ALU op, and 0 for NOP, STORE, PUSH or a non-live op.
REQ-019 MEMWB_ra, MEMWB_valid and MEMWB_flags SHALL copy EXMEM_ra, EXMEM_valid and EXMEM_flags with a latency of exactly 1 cycle.
REQ-020 When stall=1, RAM, SP and all MEMWB outputs SHALL hold their values.
REQ-021 Priority SHALL be reset > flush > stall.
REQ-022 Flush SHALL zero all MEMWB outputs, block any RAM write, and leave SP unchanged.
REQ-023 SP wrap: PUSH at SP=8'h00 SHALL write RAM[00] and give SP=8'hFF; POP at SP=8'hFF SHALL read RAM[00] and give SP=8'h00.
REQ-024 STORE and PUSH to the same address in consecutive cycles SHALL serialize; a LOAD immediately after a STORE SHALL see the new data.

Reset
REQ-025 Asserting reset (reset=0) SHALL immediately clear MEMWB_data, MEMWB_ra, MEMWB_wen, MEMWB_valid and MEMWB_flags to 0, and set SP to SP_INIT.
REQ-026 Reset SHALL NOT clear RAM contents.
REQ-027 Reset asserted mid-PUSH SHALL block the write and restore SP to SP_INIT.

Configuration
REQ-028 Macro MEM_STAGE_STACK_EN defined: PUSH and POP SHALL behave as specified above.
REQ-029 MEM_STAGE_STACK_EN undefined: PUSH and POP SHALL act as NOP (no RAM write, MEMWB_wen=0, valid passes through), no SP register SHALL be built, and sp_out SHALL be tied to SP_INIT.

Structure
REQ-030 Opcode constants (NOP, LOAD, STORE, PUSH, POP) and SP_INIT SHALL live in the shared processor package.
REQ-031 The RAM SHALL be the single sub-module data_ram: one write port, one asynchronous read port, DEPTH x 8.

Verification
REQ-032 Reset, then STORE addr=8'h10 data=8'hA5, then LOAD addr=8'h10 ra=2 -> MEMWB_data=8'hA5, MEMWB_wen=1, MEMWB_ra=2.
REQ-033 PUSH 8'h3C, then POP ra=1 -> SP goes 8'hFF, 8'hFE, 8'hFF; MEMWB_data=8'h3C.
REQ-034 Force SP to 8'h00 via 255 PUSHes, then PUSH 8'h77 -> RAM[00]=8'h77, sp_out=8'hFF.
REQ-035 STORE with stall=1 for 2 cycles, then stall=0 -> exactly one write; MEMWB outputs hold during the stall.
REQ-036 flush=1 together with stall=1 on a valid STORE -> no write; MEMWB_valid=0 and MEMWB_data=0 on the next cycle.
REQ-037 reset asserted during a PUSH of 8'h55 -> outputs clear immediately, SP=8'hFF, RAM[SP] unchanged; without MEM_STAGE_STACK_EN, PUSH -> MEMWB_wen=0 and sp_out=8'hFF.
